// File: rtl/dcl_period_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dcl_period_meter: measures high time and period of sig_in in clk_in cycles.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dcl_period_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] hi_latch, hi_latch_nx;
  logic [CNT_W-1:0] high_nx, period_nx;
  logic             done_nx, timeout_nx, busy_nx;
  logic             rise, fall, at_limit;
  logic [CNT_W-1:0] cnt_inc;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign at_limit = (cnt == TMO_VAL);
  // Saturate so an edge landing exactly on the limit cannot wrap the count.
  assign cnt_inc  = at_limit ? cnt : cnt + ONE;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      hi_latch   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      state      <= state_nx;
      cnt        <= cnt_nx;
      hi_latch   <= hi_latch_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      timeout    <= timeout_nx;
      high_cnt   <= high_nx;
      period_cnt <= period_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    hi_latch_nx = hi_latch;
    done_nx     = 1'b0;
    timeout_nx  = timeout;
    high_nx     = high_cnt;
    period_nx   = period_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ARM;
          cnt_nx   = '0;
        end
      end
      ARM: begin
        if (rise) begin
          state_nx = HIGH;
          cnt_nx   = ONE;
        end else if (at_limit) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      HIGH: begin
        if (fall) begin
          state_nx    = LOW;
          hi_latch_nx = cnt;
          cnt_nx      = cnt_inc;
        end else if (at_limit) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          period_nx  = cnt;
          high_nx    = hi_latch;
          done_nx    = 1'b1;
          timeout_nx = 1'b0;
          // The terminating rise doubles as the start of the next period.
          if (cont) begin
            state_nx = HIGH;
            cnt_nx   = ONE;
          end else begin
            state_nx = IDLE;
          end
        end else if (at_limit) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort path: only reached when no terminating edge took priority.
    if (state != IDLE && state_nx == IDLE && !done_nx) begin
      done_nx    = 1'b1;
      timeout_nx = 1'b1;
      high_nx    = '0;
      period_nx  = '0;
    end

    busy_nx = (state_nx != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_dcl_period_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dcl_period_meter: scoreboard bench with a behavioural divider on sig_in.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dcl_period_meter;

  localparam int H1 = 849;
  localparam int P1 = 4245;
  localparam int H0 = 5625;
  localparam int P0 = 28121;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sig_in = 1'b0;
  logic        start  = 1'b0;
  logic        cont   = 1'b0;
  logic        busy, done, timeout;
  logic [15:0] high_cnt, period_cnt;

  logic        t_sig   = 1'b0;
  logic        t_start = 1'b0;
  logic        t_cont  = 1'b0;
  logic        t_busy, t_done, t_timeout;
  logic [15:0] t_high, t_period;

  dcl_period_meter #(.CNT_W(16), .TIMEOUT_CYC(65535)) u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy), .done(done), .timeout(timeout),
    .high_cnt(high_cnt), .period_cnt(period_cnt)
  );

  dcl_period_meter #(.CNT_W(16), .TIMEOUT_CYC(1000)) u_dut_tmo (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(t_sig), .start(t_start), .cont(t_cont),
    .busy(t_busy), .done(t_done), .timeout(t_timeout),
    .high_cnt(t_high), .period_cnt(t_period)
  );

  initial forever #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc[$];

  typedef struct {
    int hi;
    int per;
    bit tmo;
    bit dc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Scoreboard monitor: every done pops one expectation.
  initial forever begin
    @(negedge clk_in);
    if (rst_n && done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (!mon_e.dc) begin
          check("high_cnt", {16'd0, high_cnt}, mon_e.hi);
          check("period_cnt", {16'd0, period_cnt}, mon_e.per);
        end
        check("timeout_flag", {31'd0, timeout}, {31'd0, mon_e.tmo});
      end
    end
  end

  // Behavioural divider: high while phase < gen_h, period gen_p.
  int gen_h = H1;
  int gen_p = P1;
  int gen_phase = 0;
  bit gen_set = 1'b0;
  int gen_set_val = 0;

  initial forever begin
    @(negedge clk_in);
    if (gen_set) begin
      gen_phase = gen_set_val;
      gen_set   = 1'b0;
    end else begin
      gen_phase = (gen_phase + 1 >= gen_p) ? 0 : gen_phase + 1;
    end
    sig_in = (gen_phase < gen_h);
  end

  // Select divider setting and place the phase 20 cycles before a rise.
  task automatic div_sel(input bit sel);
    @(posedge clk_in);
    gen_h       = sel ? H1 : H0;
    gen_p       = sel ? P1 : P0;
    gen_set_val = gen_p - 20;
    gen_set     = 1'b1;
  endtask

  task automatic push_exp(input int hi, input int per, input bit tmo, input bit dc);
    exp_t e;
    e.hi = hi; e.per = per; e.tmo = tmo; e.dc = dc;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clk_in);
      k++;
    end
    check("done_wait", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  int base;
  int k;

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_high", {16'd0, high_cnt}, 32'd0);
    check("rst_period", {16'd0, period_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Timeout: sig held low, limit 1000
    t_start = 1'b1;
    @(negedge clk_in);
    t_start = 1'b0;
    k = 1;
    check("tmo_busy", {31'd0, t_busy}, 32'd1);
    while (!t_done && k < 1100) begin
      @(negedge clk_in);
      k++;
    end
    check("tmo_done", {31'd0, t_done}, 32'd1);
    check("tmo_latency", k, 32'd1002);
    check("tmo_flag", {31'd0, t_timeout}, 32'd1);
    check("tmo_high", {16'd0, t_high}, 32'd0);
    check("tmo_period", {16'd0, t_period}, 32'd0);
    @(negedge clk_in);
    check("tmo_done_pulse", {31'd0, t_done}, 32'd0);
    check("tmo_idle", {31'd0, t_busy}, 32'd0);
    check("tmo_hold", {31'd0, t_timeout}, 32'd1);

    // Single shot, sel=1
    base = done_cnt;
    push_exp(H1, P1, 1'b0, 1'b0);
    div_sel(1'b1);
    pulse_start();
    check("ss_busy", {31'd0, busy}, 32'd1);
    wait_done(base + 1, 10000);
    @(negedge clk_in);
    check("ss_idle", {31'd0, busy}, 32'd0);
    check("ss_hold_high", {16'd0, high_cnt}, H1);

    // Repeated start while busy is ignored
    base = done_cnt;
    push_exp(H1, P1, 1'b0, 1'b0);
    div_sel(1'b1);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      repeat (500) @(negedge clk_in);
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
    end
    wait_done(base + 1, 10000);
    repeat (20) @(negedge clk_in);
    check("rs_single_done", done_cnt, base + 1);
    check("rs_idle", {31'd0, busy}, 32'd0);

    // Continuous sel=1, then toggle to sel=0
    base = done_cnt;
    cont = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(H1, P1, 1'b0, 1'b0);
    div_sel(1'b1);
    pulse_start();
    wait_done(base + 3, 20000);
    check("cont_space0", done_cyc[base + 1] - done_cyc[base], P1);
    check("cont_space1", done_cyc[base + 2] - done_cyc[base + 1], P1);
    check("cont_busy", {31'd0, busy}, 32'd1);
    push_exp(0, 0, 1'b0, 1'b1);
    div_sel(1'b0);
    wait_done(base + 4, 1000);
    @(negedge clk_in);
    cont = 1'b0;
    push_exp(H0, P0, 1'b0, 1'b0);
    wait_done(base + 5, 30000);
    @(negedge clk_in);
    check("sel0_idle", {31'd0, busy}, 32'd0);

    // Reset during HIGH discards the measurement
    base = done_cnt;
    div_sel(1'b1);
    pulse_start();
    repeat (40) @(negedge clk_in);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    check("mid_rst_high", {16'd0, high_cnt}, 32'd0);
    check("mid_rst_period", {16'd0, period_cnt}, 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_in);
    check("mid_no_done", done_cnt, base);
    push_exp(H1, P1, 1'b0, 1'b0);
    div_sel(1'b1);
    pulse_start();
    wait_done(base + 1, 10000);
    @(negedge clk_in);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
